// File: rtl/rsc_hard_checker.sv
// rsc_hard_checker
// ----------------
// Hard-decision checker for one LTE constituent RSC encoder stream
// (feedback g0 = 1+D^2+D^3, feedforward g1 = 1+D+D^3). The systematic bits
// are re-encoded locally. Every received parity bit and both bits of each of
// the 3 trellis-termination pairs are compared against the local encoder.
// Each disagreeing bit is counted. The systematic data bits are forwarded as
// the recovered information bits.
//
// Parameters:
//   K  - information bits per block (40..6144)
//   CW - width of the in-block counter
//   EW - width of the saturating mismatch counter
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset
//   enable     - clock enable; every register holds while low
//   in_valid   - a (sys_bit, par_bit) pair is presented this cycle
//   sys_bit    - systematic bit (tail systematic bit during termination)
//   par_bit    - parity bit (tail parity bit during termination)
//   dec_bit    - recovered information bit
//   dec_valid  - one-cycle qualifier for dec_bit, one per information bit
//   err_count  - mismatches in the current/last block, saturating
//   block_done - one-cycle pulse after the last tail pair of a block
//   block_ok   - 1 iff the finished block had no mismatches, held until the
//                next block starts

module rsc_hard_checker #(
    parameter int K  = 6144,
    parameter int CW = 13,
    parameter int EW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          in_valid,
    input  logic          sys_bit,
    input  logic          par_bit,
    output logic          dec_bit,
    output logic          dec_valid,
    output logic [EW-1:0] err_count,
    output logic          block_done,
    output logic          block_ok
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST_DATA = CW'(K - 1);
    localparam logic [CW-1:0] LAST_TAIL = CW'(2);

    state_t        state_q, state_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic          s3_q, s3_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [EW-1:0] err_q, err_d;
    logic          dec_bit_q, dec_bit_d;
    logic          dec_valid_q, dec_valid_d;
    logic          done_q, done_d;
    logic          ok_q, ok_d;

    logic          s1_e, s2_e, s3_e;
    logic          fb_a, exp_z, exp_tsys, exp_tpar;
    logic [1:0]    err_inc;
    logic [EW-1:0] err_base;
    logic [EW:0]   err_sum;
    logic [EW-1:0] err_next;

    // A new block always starts from the all-zero encoder state and an empty
    // error count, so in IDLE the stored values are masked off rather than
    // cleared a cycle early.
    assign s1_e     = (state_q == IDLE) ? 1'b0 : s1_q;
    assign s2_e     = (state_q == IDLE) ? 1'b0 : s2_q;
    assign s3_e     = (state_q == IDLE) ? 1'b0 : s3_q;
    assign err_base = (state_q == IDLE) ? '0 : err_q;

    // Local encoder: data steps use the recursive feedback bit. Tail steps
    // feed back the bit that drives the register to zero, and that bit is
    // exactly the expected tail systematic bit.
    assign fb_a     = sys_bit ^ s2_e ^ s3_e;
    assign exp_z    = fb_a ^ s1_e ^ s3_e;
    assign exp_tsys = s2_e ^ s3_e;
    assign exp_tpar = s1_e ^ s3_e;

    // Tail pairs can add two mismatches at once, data pairs at most one.
    assign err_inc = (state_q == TAIL)
                   ? ({1'b0, sys_bit ^ exp_tsys} + {1'b0, par_bit ^ exp_tpar})
                   : {1'b0, par_bit ^ exp_z};

    // One extra bit catches the carry so the counter can clamp instead of wrap.
    assign err_sum  = {1'b0, err_base} + {{(EW-1){1'b0}}, err_inc};
    assign err_next = err_sum[EW] ? {EW{1'b1}} : err_sum[EW-1:0];

    // Next-state logic. Pulses default low so they last one enabled cycle.
    // DONE never looks at in_valid, so a pair offered there is dropped.
    always_comb begin
        state_d     = state_q;
        s1_d        = s1_q;
        s2_d        = s2_q;
        s3_d        = s3_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        dec_bit_d   = dec_bit_q;
        dec_valid_d = 1'b0;
        done_d      = 1'b0;
        ok_d        = ok_q;

        case (state_q)
            IDLE, DATA: begin
                if (in_valid) begin
                    s1_d        = fb_a;
                    s2_d        = s1_e;
                    s3_d        = s2_e;
                    err_d       = err_next;
                    dec_bit_d   = sys_bit;
                    dec_valid_d = 1'b1;
                    if (state_q == IDLE) begin
                        ok_d = 1'b0;
                    end
                    if (state_q == DATA && cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
                        state_d = TAIL;
                    end else begin
                        cnt_d   = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
                        state_d = DATA;
                    end
                end
            end
            TAIL: begin
                if (in_valid) begin
                    s1_d  = 1'b0;
                    s2_d  = s1_q;
                    s3_d  = s2_q;
                    err_d = err_next;
                    if (cnt_q == LAST_TAIL) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        ok_d    = (err_next == '0);
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset wins over enable. A low enable freezes
    // everything, including the output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            cnt_q       <= '0;
            err_q       <= '0;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
        end else if (enable) begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            dec_bit_q   <= dec_bit_d;
            dec_valid_q <= dec_valid_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
        end
    end

    assign dec_bit    = dec_bit_q;
    assign dec_valid  = dec_valid_q;
    assign err_count  = err_q;
    assign block_done = done_q;
    assign block_ok   = ok_q;

endmodule

// File: doc/rsc_hard_checker.md
Name: rsc_hard_checker

Overview:
- Receive-side companion to the turbo encoder block.
- Consumes serial (systematic, parity) bit pairs from one LTE constituent RSC encoder (g0 = 1+D^2+D^3 feedback, g1 = 1+D+D^3 feedforward).
- Re-encodes the systematic stream locally, checks every parity bit and the 3 trellis-termination tail pairs, and forwards the recovered information bits.
- Reports a per-block mismatch count and pass flag. Used in full-chip verification and as the hard-decision front end ahead of a future soft decoder.

Parameters:
- K, 6144, information bits per block (legal range 40..6144)
- CW, 13, width of the in-block bit counter (must hold K+3)
- EW, 16, width of the error counter (saturating)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  clock-enable; when low, all state and outputs hold
- in_valid  input  1  sys_bit/par_bit pair presented this cycle
- sys_bit  input  1  systematic bit (tail phase: tail systematic bit)
- par_bit  input  1  parity bit (tail phase: tail parity bit)
- dec_bit  output  1  recovered information bit
- dec_valid  output  1  dec_bit qualifier, one-cycle pulse per info bit
- err_count  output  EW  mismatches in current/last block, saturates at all-ones
- block_done  output  1  one-cycle pulse after last tail pair of a block
- block_ok  output  1  valid with block_done, held until next block starts; 1 iff err_count==0

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset values: dec_bit=0, dec_valid=0, err_count=0, block_done=0, block_ok=0, state=IDLE, RSC register s1s2s3=000, counter=0.
- A pair is accepted in a cycle when enable=1 and in_valid=1. in_valid low stalls; gaps of any length are allowed and change no state.
- When enable=0, every register holds, including the dec_valid/block_done pulses. Pulses therefore stretch until enable returns.
- FSM states: IDLE, DATA, TAIL, DONE.
  - IDLE: first accepted pair starts a block. Clear err_count and block_ok, set s=000, process the pair as data index 0, go to DATA.
  - DATA: per accepted pair, feedback a = sys_bit^s2^s3, expected z = a^s1^s3, next s = (a,s1,s2). After data index K-1, go to TAIL.
  - TAIL: 3 accepted pairs. Expected sys = s2^s3, expected par = s1^s3, next s = (0,s1,s2). Each mismatching bit (sys and par separately) increments err_count, so at most +2 per pair. After the 3rd tail pair, go to DONE.
  - DONE: one cycle. block_done=1, block_ok=(err_count==0). Then go to IDLE. An in_valid pair presented during DONE is ignored (not accepted).
- Data mismatch: par_bit != expected z adds +1 to err_count.
- Latency: dec_bit/dec_valid are registered, asserted the cycle after acceptance, dec_bit = sys_bit. Tail pairs never produce dec_valid. err_count reflects a pair the cycle after acceptance.
- Exactly K dec_valid pulses per block.
- err_count saturates at 2^EW-1, with no wrap.
- Reset asserted mid-block: next cycle all registers are at reset values. The partial block is discarded and no block_done is issued.
- Final state after a correct tail is 000. A nonzero state is not flagged separately; it already shows up as tail mismatches.

Test Plan:
- K=40, 43 pairs all (0,0) with no gaps -> 40 dec_valid pulses, dec_bit=0; block_done one cycle after 43rd pair; err_count=0, block_ok=1.
- K=40, sys=1,0,0,0,0 then zeros; parity = 1,1,1,1,0 (impulse response), then remaining parity and tail from the golden encoder -> err_count=0, block_ok=1, dec_bit stream 1,0,0,0,0...
- Same block with the parity of data index 2 flipped -> err_count=1, block_ok=0; dec_bit stream unchanged.
- Correct data, tail pair 1 with both bits flipped -> err_count=2, block_ok=0.
- Gaps: in_valid low for 5 cycles between every pair, plus enable=0 for 3 cycles mid-block -> outputs identical to the gap-free run apart from timing; no extra or missing dec_valid pulses.
- Reset asserted after data index 20, then a fresh correct 43-pair block -> no block_done for the aborted block; new block gives err_count=0, block_ok=1, exactly 40 dec_valid pulses.
